// File: rtl/main_button_pio_debounced.sv
// Avalon-MM input PIO for buttons/switches: per-bit synchroniser, debounce,
// edge capture with write-1-to-clear, interrupt mask and a level IRQ.
module main_button_pio_debounced #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clear_bits;
  logic [CW-1:0]    count [WIDTH];
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= RESET_LEVEL;
      sync_out  <= RESET_LEVEL;
    end else begin
      sync_meta <= in_port;
      sync_out  <= sync_meta;
    end
  end

  // Any return to the stable level clears the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= RESET_LEVEL;
      stable_d <= RESET_LEVEL;
      for (int i = 0; i < WIDTH; i++) count[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_LAST) begin
          stable[i] <= sync_out[i];
          count[i]  <= '0;
        end else begin
          count[i] <= count[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    edge_event = stable ^ stable_d;
    if (EDGE_TYPE == 0)      edge_event = stable & ~stable_d;
    else if (EDGE_TYPE == 1) edge_event = ~stable & stable_d;
  end

  always_comb begin
    clear_bits = '0;
    if (wr_en && address == 2'd3) clear_bits = writedata[WIDTH-1:0];
  end

  // A new event outranks a simultaneous clear so no press is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
      irqmask <= '0;
      irq     <= 1'b0;
    end else begin
      edgecap <= (edgecap & ~clear_bits) | edge_event;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      irq <= |(edgecap & irqmask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(stable);
        2'd2:    readdata <= 32'(irqmask);
        2'd3:    readdata <= 32'(edgecap);
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_main_button_pio_debounced.sv
// Self-checking bench: falling-edge instance for the register/debounce tests,
// any-edge instance for both-transition capture and mid-count reset.
module tb_main_button_pio_debounced;

  localparam int W  = 4;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         resetNA, resetNB;
  logic [1:0]   address;
  logic         chipselect, writeN;
  logic [31:0]  writedata;
  logic [W-1:0] inA, inB;
  logic [31:0]  rdA, rdB;
  logic         irqA, irqB;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          selB;
  } readExp_t;

  readExp_t expQ[$];

  always #5 clk = ~clk;

  main_button_pio_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) dutA (
    .clk(clk), .reset_n(resetNA), .address(address), .chipselect(chipselect),
    .write_n(writeN), .writedata(writedata), .in_port(inA),
    .readdata(rdA), .irq(irqA)
  );

  main_button_pio_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) dutB (
    .clk(clk), .reset_n(resetNB), .address(address), .chipselect(chipselect),
    .write_n(writeN), .writedata(writedata), .in_port(inB),
    .readdata(rdB), .irq(irqB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    writeN     = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    writeN     = 1'b1;
  endtask

  task automatic collectRead();
    readExp_t e;
    e = expQ.pop_front();
    checkOutput(e.tag, e.selB ? rdB : rdA, e.exp);
  endtask

  // Readdata is registered, so the expectation is checked one cycle later.
  task automatic busRead(input bit selB, input logic [1:0] addr,
                         input logic [31:0] exp, input string tag);
    readExp_t e;
    address = addr;
    e.tag   = tag;
    e.exp   = exp;
    e.selB  = selB;
    expQ.push_back(e);
    @(negedge clk);
    collectRead();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetNA    = 1'b0;
    resetNB    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    writeN     = 1'b1;
    writedata  = '0;
    inA        = 4'hF;
    inB        = 4'hF;
    waitCycles(2);
    checkOutput("rst_rdA", rdA, 32'h0);
    checkOutput("rst_irqA", {31'b0, irqA}, 32'h0);
    resetNA = 1'b1;
    resetNB = 1'b1;

    busRead(0, 2'd0, 32'hF, "rst_data");
    busRead(0, 2'd2, 32'h0, "rst_mask");
    busRead(0, 2'd3, 32'h0, "rst_ecap");
    checkOutput("rst_irq", {31'b0, irqA}, 32'h0);

    // Bit0 press: stable moves 2+DC edges later, readdata one edge after.
    address = 2'd0;
    inA     = 4'hE;
    waitCycles(2 + DC);
    checkOutput("data_early", rdA, 32'hF);
    waitCycles(1);
    checkOutput("data_lat", rdA, 32'hE);
    busRead(0, 2'd3, 32'h1, "ecap_b0");
    checkOutput("irq_masked", {31'b0, irqA}, 32'h0);

    inA = 4'hF;
    waitCycles(12);
    busRead(0, 2'd3, 32'h1, "ecap_norise");
    busWrite(2'd3, 32'h1);
    busRead(0, 2'd3, 32'h0, "ecap_clr");

    busWrite(2'd2, 32'h1);
    busRead(0, 2'd2, 32'h1, "mask_rd");
    inA = 4'hE;
    waitCycles(3 + DC);
    checkOutput("irq_early", {31'b0, irqA}, 32'h0);
    waitCycles(1);
    checkOutput("irq_set", {31'b0, irqA}, 32'h1);
    busWrite(2'd3, 32'h2);
    busRead(0, 2'd3, 32'h1, "w1c_other");
    checkOutput("irq_keep", {31'b0, irqA}, 32'h1);
    busWrite(2'd3, 32'h1);
    checkOutput("irq_lag", {31'b0, irqA}, 32'h1);
    waitCycles(1);
    checkOutput("irq_clr", {31'b0, irqA}, 32'h0);
    busRead(0, 2'd3, 32'h0, "ecap_clr2");
    inA = 4'hF;
    waitCycles(12);

    // Bounce on bit1: 5 low, 2 high, 7 low must not be accepted yet.
    inA = 4'hD;
    waitCycles(5);
    inA = 4'hF;
    waitCycles(2);
    inA = 4'hD;
    waitCycles(7);
    busRead(0, 2'd0, 32'hF, "bounce_data");
    busRead(0, 2'd3, 32'h0, "bounce_ecap");
    waitCycles(3);
    busRead(0, 2'd0, 32'hD, "bounce_accept");
    busRead(0, 2'd3, 32'h2, "bounce_edge");

    // Bit2 event coincides with a clear of bit2: the event must survive.
    inA = 4'h9;
    waitCycles(2 + DC);
    busWrite(2'd3, 32'h4);
    busRead(0, 2'd3, 32'h6, "set_wins");
    busWrite(2'd3, 32'hF);
    busRead(0, 2'd3, 32'h0, "ecap_all_clr");

    busWrite(2'd0, 32'h0);
    busRead(0, 2'd0, 32'h9, "data_ro");
    busWrite(2'd1, 32'hF);
    busRead(0, 2'd1, 32'h0, "addr1_zero");
    busWrite(2'd2, 32'hFFFF_FFFF);
    busRead(0, 2'd2, 32'hF, "mask_width");

    // Any-edge instance: both press and release capture.
    busWrite(2'd2, 32'h8);
    inB = 4'h7;
    waitCycles(3 + DC);
    busRead(1, 2'd3, 32'h8, "any_fall");
    checkOutput("irqB_set", {31'b0, irqB}, 32'h1);
    busWrite(2'd3, 32'h8);
    busRead(1, 2'd3, 32'h0, "any_clr");
    checkOutput("irqB_clr", {31'b0, irqB}, 32'h0);
    inB = 4'hF;
    waitCycles(3 + DC);
    busRead(1, 2'd3, 32'h8, "any_rise");
    checkOutput("irqB_rise", {31'b0, irqB}, 32'h1);

    inB = 4'h7;
    waitCycles(5);
    resetNB = 1'b0;
    #1;
    checkOutput("midrst_rd", rdB, 32'h0);
    checkOutput("midrst_irq", {31'b0, irqB}, 32'h0);
    waitCycles(2);
    inB     = 4'hF;
    resetNB = 1'b1;
    waitCycles(15);
    busRead(1, 2'd0, 32'hF, "rstB_data");
    busRead(1, 2'd3, 32'h0, "rstB_noedge");
    busRead(1, 2'd2, 32'h0, "rstB_mask");
    checkOutput("rstB_irq", {31'b0, irqB}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
